// File: rtl/ilowx_arbiter_pkg.sv
// Shared types for the lowX channel arbiter. The fixed-width ilowX aliases
// correspond to a single-channel, 32-bit address, 128-bit block configuration.
package ilowx_arbiter_pkg;

  localparam int LOWX_N_CH = 2;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP} lowx_arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        uncached;
  } ilowX_req_t;

  typedef struct packed {
    logic         valid;
    logic [127:0] blk;
  } ilowX_res_t;

endpackage

// File: rtl/ilowx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping modulo N_CH.
module lowx_rr_pick
  import ilowx_arbiter_pkg::*;
#(
  parameter int N_CH = LOWX_N_CH,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] win,
  output logic            any
);

  int idx;

  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(ptr) + i) % N_CH;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ilowx_arbiter.sv
// N-channel round-robin arbiter onto a single lowX port, one transaction in flight.
// Optional macro ILOWX_ARB_UNCACHED_PRIO_EN gives uncached requests priority.
module ilowx_arbiter
  import ilowx_arbiter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128,
  parameter int N_CH     = LOWX_N_CH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_CH-1:0]        ch_req_valid_i,
  output logic [N_CH-1:0]        ch_req_ready_o,
  input  logic [N_CH*XLEN-1:0]   ch_req_addr_i,
  input  logic [N_CH-1:0]        ch_req_uncached_i,
  output logic [N_CH-1:0]        ch_res_valid_o,
  input  logic [N_CH-1:0]        ch_res_ready_i,
  output logic [BLK_SIZE-1:0]    ch_res_blk_o,
  output logic                   lowx_req_valid_o,
  input  logic                   lowx_req_ready_i,
  output logic [XLEN-1:0]        lowx_req_addr_o,
  output logic                   lowx_req_uncached_o,
  input  logic                   lowx_res_valid_i,
  output logic                   lowx_res_ready_o,
  input  logic [BLK_SIZE-1:0]    lowx_res_blk_i,
  output logic                   busy_o
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  lowx_arb_state_t state, state_nx;
  logic [CH_W-1:0] rr_ptr, gnt, ptr_nx, win, win_all;
  logic            any_all, grant;
  logic [XLEN-1:0] addr_q;
  logic            unc_q;
  logic [BLK_SIZE-1:0] blk_q;

  lowx_rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick_all (
    .req(ch_req_valid_i), .ptr(rr_ptr), .win(win_all), .any(any_all)
  );

`ifdef ILOWX_ARB_UNCACHED_PRIO_EN
  logic [CH_W-1:0] win_unc;
  logic            any_unc;

  // Uncached winners shadow the full set but share the same pointer.
  lowx_rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick_unc (
    .req(ch_req_valid_i & ch_req_uncached_i), .ptr(rr_ptr), .win(win_unc), .any(any_unc)
  );
  assign win = any_unc ? win_unc : win_all;
`else
  assign win = win_all;
`endif

  assign grant  = (state == ARB_IDLE) && any_all;
  // Wraps to 0 after the last channel; with one channel this is always 0.
  assign ptr_nx = (gnt == CH_W'(N_CH - 1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      addr_q <= '0;
      unc_q  <= 1'b0;
      blk_q  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        gnt    <= win;
        addr_q <= ch_req_addr_i[win*XLEN +: XLEN];
        unc_q  <= ch_req_uncached_i[win];
      end
      if (state == ARB_WAIT && lowx_res_valid_i) blk_q <= lowx_res_blk_i;
      if (state == ARB_RESP && ch_res_ready_i[gnt]) rr_ptr <= ptr_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    ch_req_ready_o   = '0;
    ch_res_valid_o   = '0;
    lowx_req_valid_o = 1'b0;
    lowx_res_ready_o = 1'b0;
    case (state)
      ARB_IDLE: if (any_all) begin
        ch_req_ready_o[win] = 1'b1;
        state_nx            = ARB_REQ;
      end
      ARB_REQ: begin
        lowx_req_valid_o = 1'b1;
        if (lowx_req_ready_i) state_nx = ARB_WAIT;
      end
      ARB_WAIT: begin
        lowx_res_ready_o = 1'b1;
        if (lowx_res_valid_i) state_nx = ARB_RESP;
      end
      ARB_RESP: begin
        ch_res_valid_o[gnt] = 1'b1;
        if (ch_res_ready_i[gnt]) state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  assign lowx_req_addr_o     = addr_q;
  assign lowx_req_uncached_o = unc_q;
  assign ch_res_blk_o        = blk_q;
  assign busy_o              = (state != ARB_IDLE);

endmodule

// File: tb/tb_ilowx_arbiter.sv
// Self-checking bench for ilowx_arbiter (4 channels): directed steps plus a
// randomized phase, all checked against a transaction-level reference model.
module tb_ilowx_arbiter;

  localparam int XLEN = 32;
  localparam int BLK  = 128;
  localparam int N    = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]      ch_req_valid, ch_req_ready, ch_req_unc, ch_res_valid, ch_res_ready;
  logic [N*XLEN-1:0] ch_req_addr;
  logic [BLK-1:0]    ch_res_blk, lowx_res_blk;
  logic              lowx_req_valid, lowx_req_ready, lowx_req_unc;
  logic              lowx_res_valid, lowx_res_ready, busy;
  logic [XLEN-1:0]   lowx_req_addr;

  always #5 clk = ~clk;

  ilowx_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK), .N_CH(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_req_valid_i(ch_req_valid), .ch_req_ready_o(ch_req_ready),
    .ch_req_addr_i(ch_req_addr), .ch_req_uncached_i(ch_req_unc),
    .ch_res_valid_o(ch_res_valid), .ch_res_ready_i(ch_res_ready), .ch_res_blk_o(ch_res_blk),
    .lowx_req_valid_o(lowx_req_valid), .lowx_req_ready_i(lowx_req_ready),
    .lowx_req_addr_o(lowx_req_addr), .lowx_req_uncached_o(lowx_req_unc),
    .lowx_res_valid_i(lowx_res_valid), .lowx_res_ready_o(lowx_res_ready),
    .lowx_res_blk_i(lowx_res_blk), .busy_o(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // requesters
  bit              rq_v[N];
  logic [XLEN-1:0] rq_a[N];
  bit              rq_u[N];
  // reference: phase 0 idle, 1 issuing to lowX, 2 awaiting data, 3 returning
  int              m_phase, m_ptr, m_gnt;
  logic [XLEN-1:0] m_addr;
  bit              m_unc;
  logic [BLK-1:0]  m_blk;
  // lowX memory
  bit              mem_pend;
  int              mem_dly;
  logic [BLK-1:0]  mem_blk, blk_override;
  // stimulus knobs
  int pct_new, pct_unc, pct_lrdy, pct_crdy, min_lat, max_lat;
  bit spurious;
  int grants[$];
  int n_done;

  task automatic check(string tag, logic [BLK-1:0] obs, logic [BLK-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Nearest requester at or after the pointer, by circular distance.
  function automatic int pick_ch();
    int best, bestd, d;
    bit any_unc;
    best = -1; bestd = N; any_unc = 1'b0;
`ifdef ILOWX_ARB_UNCACHED_PRIO_EN
    for (int k = 0; k < N; k++) if (rq_v[k] && rq_u[k]) any_unc = 1'b1;
`endif
    for (int k = 0; k < N; k++) begin
      d = (k - m_ptr + N) % N;
      if (rq_v[k] && (!any_unc || rq_u[k]) && d < bestd) begin
        bestd = d;
        best  = k;
      end
    end
    return best;
  endfunction

  function automatic bit any_req();
    bit a = 1'b0;
    for (int k = 0; k < N; k++) a |= rq_v[k];
    return a;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      ch_req_valid[k]               = rq_v[k];
      ch_req_addr[k*XLEN +: XLEN]   = rq_a[k];
      ch_req_unc[k]                 = rq_u[k];
    end
  endtask

  // One clock: drive at edge+1, sample at edge+2, then advance the model.
  task automatic step();
    int w;
    logic [N-1:0] exp_rdy, exp_res;
    for (int k = 0; k < N; k++)
      if (!rq_v[k] && $urandom_range(99) < pct_new) begin
        rq_v[k] = 1'b1;
        rq_a[k] = $urandom;
        rq_u[k] = ($urandom_range(99) < pct_unc);
      end
    drive();
    lowx_req_ready = ($urandom_range(99) < pct_lrdy);
    if (mem_pend) begin
      lowx_res_valid = (mem_dly == 0);
      lowx_res_blk   = (mem_dly == 0) ? mem_blk : {$urandom, $urandom, $urandom, $urandom};
    end else begin
      lowx_res_valid = spurious && ($urandom_range(1) == 1);
      lowx_res_blk   = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int k = 0; k < N; k++) ch_res_ready[k] = ($urandom_range(99) < pct_crdy);
    #1;
    w = (m_phase == 0) ? pick_ch() : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_res = '0;
    if (m_phase == 3) exp_res[m_gnt] = 1'b1;
    check("ch_req_ready", BLK'(ch_req_ready), BLK'(exp_rdy));
    check("busy", BLK'(busy), BLK'(m_phase != 0));
    check("lowx_req_valid", BLK'(lowx_req_valid), BLK'(m_phase == 1));
    check("lowx_res_ready", BLK'(lowx_res_ready), BLK'(m_phase == 2));
    check("ch_res_valid", BLK'(ch_res_valid), BLK'(exp_res));
    if (m_phase == 1) begin
      check("lowx_req_addr", BLK'(lowx_req_addr), BLK'(m_addr));
      check("lowx_req_uncached", BLK'(lowx_req_unc), BLK'(m_unc));
    end
    if (m_phase == 3) check("ch_res_blk", ch_res_blk, m_blk);
    @(posedge clk);
    case (m_phase)
      0: if (w >= 0) begin
        m_gnt = w; m_addr = rq_a[w]; m_unc = rq_u[w];
        rq_v[w] = 1'b0;
        grants.push_back(w);
        m_phase = 1;
      end
      1: if (lowx_req_ready) begin
        m_phase  = 2;
        mem_pend = 1'b1;
        mem_dly  = $urandom_range(max_lat, min_lat);
        mem_blk  = (blk_override != '0) ? blk_override
                                        : {$urandom, $urandom, $urandom, $urandom};
      end
      2: if (lowx_res_valid) begin
        m_blk    = lowx_res_blk;
        mem_pend = 1'b0;
        m_phase  = 3;
      end else if (mem_dly > 0) mem_dly--;
      3: if (ch_res_ready[m_gnt]) begin
        m_ptr   = (m_gnt + 1) % N;
        m_phase = 0;
        n_done++;
      end
      default: ;
    endcase
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    m_phase = 0; m_ptr = 0; mem_pend = 1'b0;
    for (int k = 0; k < N; k++) rq_v[k] = 1'b0;
    drive();
    lowx_req_ready = 1'b0; lowx_res_valid = 1'b0; ch_res_ready = '0;
    #1;
    check("rst_ch_req_ready", BLK'(ch_req_ready), '0);
    check("rst_ch_res_valid", BLK'(ch_res_valid), '0);
    check("rst_busy", BLK'(busy), '0);
    check("rst_lowx_req_valid", BLK'(lowx_req_valid), '0);
    check("rst_lowx_res_ready", BLK'(lowx_res_ready), '0);
    check("rst_lowx_req_addr", BLK'(lowx_req_addr), '0);
    check("rst_lowx_req_uncached", BLK'(lowx_req_unc), '0);
    check("rst_ch_res_blk", ch_res_blk, '0);
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(int bound);
    int n = 0;
    pct_new = 0; pct_lrdy = 100; pct_crdy = 100;
    while ((m_phase != 0 || any_req()) && n < bound) begin
      step();
      n++;
    end
    check("drain_within_bound", BLK'(n < bound), BLK'(1));
  endtask

  initial begin
    int d0, exp_w;
    m_ptr = 0; m_phase = 0; m_gnt = 0; m_addr = '0; m_unc = 1'b0; m_blk = '0;
    mem_pend = 1'b0; mem_dly = 0; mem_blk = '0; blk_override = '0; n_done = 0;
    for (int k = 0; k < N; k++) begin rq_v[k] = 1'b0; rq_a[k] = '0; rq_u[k] = 1'b0; end
    pct_new = 0; pct_unc = 0; pct_lrdy = 100; pct_crdy = 100;
    min_lat = 0; max_lat = 0; spurious = 1'b0;
    lowx_res_blk = '0;

    // reset for 3 cycles, then idle with no requests
    do_reset(3);
    repeat (3) step();

    // single request, minimum round trip
    rq_v[0] = 1'b1; rq_a[0] = 32'h0000_1000; rq_u[0] = 1'b0;
    blk_override = 128'hDEADBEEF_01234567_89ABCDEF_00001000;
    grants.delete();
    d0 = n_done;
    repeat (4) step();
    check("single_done_in_4", BLK'(n_done - d0), BLK'(1));
    check("single_grant_ch0", BLK'(grants[0]), BLK'(0));
    step();
    blk_override = '0;

    // contention: all four requesting continuously from rr_ptr = 0
    do_reset(2);
    pct_new = 100; pct_unc = 0;
    grants.delete();
    for (int i = 0; i < 200 && grants.size() < 5; i++) step();
    check("contention_grant_count", BLK'(grants.size() >= 5), BLK'(1));
    for (int i = 0; i < 5 && i < grants.size(); i++)
      check($sformatf("contention_grant_%0d", i), BLK'(grants[i]), BLK'(i % N));
    drain(100);

    // backpressure: lowX not ready for 5 cycles, requester not ready for 3
    rq_v[3] = 1'b1; rq_a[3] = 32'hCAFE_0040; rq_u[3] = 1'b1;
    grants.delete();
    d0 = n_done;
    step();
    pct_lrdy = 0;
    repeat (5) step();
    pct_lrdy = 100;
    step();
    step();
    pct_crdy = 0;
    repeat (3) step();
    pct_crdy = 100;
    step();
    check("bp_one_txn", BLK'(n_done - d0), BLK'(1));
    check("bp_one_grant", BLK'(grants.size()), BLK'(1));
    step();

    // uncached priority: ch0 cached, ch2 uncached, rr_ptr = 0
    do_reset(1);
    rq_v[0] = 1'b1; rq_a[0] = 32'h0000_2000; rq_u[0] = 1'b0;
    rq_v[2] = 1'b1; rq_a[2] = 32'h0000_3000; rq_u[2] = 1'b1;
    grants.delete();
`ifdef ILOWX_ARB_UNCACHED_PRIO_EN
    exp_w = 2;
`else
    exp_w = 0;
`endif
    step();
    check("unc_grant", BLK'(grants[0]), BLK'(exp_w));
    check("unc_flag_out", BLK'(lowx_req_unc), BLK'(exp_w == 2));
    drain(100);

    // reset while waiting for lowX data
    rq_v[1] = 1'b1; rq_a[1] = 32'h0000_4000; rq_u[1] = 1'b0;
    min_lat = 4; max_lat = 4;
    step();
    step();
    check("in_wait_before_reset", BLK'(lowx_res_ready), BLK'(1));
    do_reset(1);
    min_lat = 0; max_lat = 0;
    rq_v[1] = 1'b1; rq_a[1] = 32'h0000_5000; rq_u[1] = 1'b0;
    rq_v[3] = 1'b1; rq_a[3] = 32'h0000_6000; rq_u[3] = 1'b0;
    grants.delete();
    d0 = n_done;
    drain(100);
    check("post_reset_first_grant", BLK'(grants[0]), BLK'(1));
    check("post_reset_done", BLK'(n_done - d0), BLK'(2));

    // randomized traffic with backpressure and stray lowX responses
    pct_unc = 50; min_lat = 0; max_lat = 3; spurious = 1'b1;
    d0 = n_done;
    for (int i = 0; i < 3000; i++) begin
      pct_new = 30; pct_lrdy = 60; pct_crdy = 60;
      step();
    end
    spurious = 1'b0;
    drain(200);
    check("random_progress", BLK'(n_done - d0 > 50), BLK'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ilowx_arbiter.md
# ilowx_arbiter

Parametrised N-channel arbiter that merges several cache-side lower-level request channels onto the single `ilowX` memory port. It is the next generation of the fixed-width, single-channel `icache_req_t`/`ilowX_req_t` pairing: a width- and channel-count-generic, round-robin arbitrated, single-outstanding bridge. Each channel supports response routing back to the granted requester. It sits between the I-cache (plus future prefetch/D-cache miss channels) and the lowX memory interface.

## Interface
- `XLEN`, 32: address width.
- `BLK_SIZE`, 128: cache block (response) width in bits.
- `N_CH`, 2: number of requester channels, ≥1; grant index width `CH_W = (N_CH>1) ? $clog2(N_CH) : 1`.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ch_req_valid_i`  in  N_CH  per-channel request valid.
- `ch_req_ready_o`  out  N_CH  per-channel request accept (one-hot or zero).
- `ch_req_addr_i`  in  N_CH*XLEN  packed addresses; channel k at `[k*XLEN +: XLEN]`.
- `ch_req_uncached_i`  in  N_CH  per-channel uncached flag.
- `ch_res_valid_o`  out  N_CH  per-channel response valid (one-hot or zero).
- `ch_res_ready_i`  in  N_CH  per-channel response accept.
- `ch_res_blk_o`  out  BLK_SIZE  shared response data, valid for the channel flagged in `ch_res_valid_o`.
- `lowx_req_valid_o`  out  1 / `lowx_req_ready_i`  in  1 / `lowx_req_addr_o`  out  XLEN / `lowx_req_uncached_o`  out  1: lower-level request.
- `lowx_res_valid_i`  in  1 / `lowx_res_ready_o`  out  1 / `lowx_res_blk_i`  in  BLK_SIZE: lower-level response.
- `busy_o`  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. The block holds one transaction in flight; no pipelining across channels.
- **IDLE:** if any `ch_req_valid_i` is set, pick a winner by round-robin starting at `rr_ptr`. Assert `ch_req_ready_o[win]` combinationally in the same cycle. Latch addr, uncached and grant index, then go to REQ. No valid requests: stay in IDLE.
- **REQ:** `lowx_req_valid_o=1` with the latched addr/uncached held stable. On `lowx_req_ready_i`, go to WAIT.
- **WAIT:** `lowx_res_ready_o=1`. On `lowx_res_valid_i`, capture `lowx_res_blk_i` into the block register and go to RESP.
- **RESP:** `ch_res_valid_o[gnt]=1` and `ch_res_blk_o` = captured block. On `ch_res_ready_i[gnt]`, set `rr_ptr = (gnt+1) mod N_CH` and go to IDLE.
- Round-robin pointer wrap: when `gnt = N_CH-1`, the pointer becomes 0.
- `ch_req_ready_o` is zero outside IDLE, so requests arriving while busy wait. Requesters hold valid until accepted.
- `ch_res_ready_i` of non-granted channels is ignored. `lowx_res_valid_i` outside WAIT is ignored.
- `N_CH=1`: the arbiter degenerates to pass-through; `rr_ptr` stays constant at 0.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, all valid/ready outputs 0, `lowx_req_addr_o`=0, `lowx_req_uncached_o`=0, `ch_res_blk_o`=0, `busy_o`=0.
- Accept at cycle t: `lowx_req_valid_o` rises at t+1.
- Minimum round trip is 4 cycles to return to IDLE: req ready at t+1, res valid at t+2, `ch_res_valid_o` at t+3, ch ready at t+3, IDLE at t+4.
- Back-to-back: the next accept can occur in the first IDLE cycle. A grant never happens in the same cycle as RESP completion.
- Reset asserted mid-operation: state returns to IDLE at once (asynchronously). The outstanding lowX transaction is abandoned, so the lowX side is reset on the same `rst_i`.

## Configuration
- Macro: `ILOWX_ARB_UNCACHED_PRIO_EN`.
- **Defined:** in IDLE, if any valid channel has uncached=1, round-robin runs only among the uncached-valid channels (same `rr_ptr`). Otherwise it runs among all valid channels.
- **Undefined:** the uncached flag is only forwarded to `lowx_req_uncached_o`; arbitration is plain round-robin.

## Structure
- `tcore_param` gains:
  - `localparam LOWX_N_CH`;
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_RESP} lowx_arb_state_t`.
- Existing `ilowX_req_t`/`ilowX_res_t` remain the fixed-width aliases for `N_CH=1`, `XLEN=32`, `BLK_SIZE=128`.
- One sub-module: `lowx_rr_pick` — combinational round-robin picker (inputs `req[N_CH]`, `ptr`; outputs `win` index and `any`). It is instantiated once, or twice under the macro (uncached set and full set).

## Test plan
- **Reset:** `rst_i` high for 3 cycles → all outputs 0, `busy_o`=0. Release, no requests → remains idle.
- **Single request:** ch0 valid, addr 0x0000_1000; lowX ready at once; res valid 1 cycle later with blk 0xDEADBEEF_…; ch0 res ready → `lowx_req_addr_o`=0x1000, `ch_res_valid_o`=0b01, blk matches, IDLE at t+4.
- **Contention (N_CH=4):** all four valid continuously → grants in order 0,1,2,3,0; each response routed only to its granted channel.
- **Backpressure:** `lowx_req_ready_i` low for 5 cycles, then `ch_res_ready_i` low for 3 cycles → addr and blk stable throughout; exactly one transaction.
- **Uncached priority (macro defined):** ch0 cached and ch2 uncached valid, `rr_ptr`=0 → ch2 granted and `lowx_req_uncached_o`=1. With the macro undefined → ch0 granted.
- **Reset mid-WAIT:** assert `rst_i` in WAIT → next edge IDLE, outputs 0, `rr_ptr`=0; subsequent request from ch1 completes normally.
